// File: rtl/mem_controller.sv
// Single-port byte-wide memory arbiter: serialises LSB loads/stores and 32-bit fetches.
// Optional MEM_IO_STALL_EN: I/O stores (addr[17:16]==2'b11) wait while io_buffer_full is high.
module mem_controller #(
  parameter int LSB_ID_WIDTH = 3,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    lsb2mem_en,
  input  logic                    lsb2mem_store_load,
  input  logic [ADDR_WIDTH-1:0]   lsb2mem_addr,
  input  logic [2:0]              lsb2mem_type,
  input  logic [31:0]             lsb2mem_val,
  input  logic [LSB_ID_WIDTH-1:0] lsb2mem_load_id,
  output logic                    mem_busy,
  output logic                    mem2lsb_load_en,
  output logic [LSB_ID_WIDTH-1:0] mem2lsb_load_id,
  output logic [31:0]             mem2lsb_load_val,
  input  logic                    if2mem_en,
  input  logic [ADDR_WIDTH-1:0]   if2mem_addr,
  output logic                    mem2if_en,
  output logic [31:0]             mem2if_inst,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              n_q, n_d;
  logic                    sext_q, sext_d;
  logic [31:0]             buf_q, buf_d;
  logic [LSB_ID_WIDTH-1:0] id_q, id_d;
  logic                    busy_q, busy_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [7:0]              dout_q, dout_d;
  logic                    lsb_en_q, lsb_en_d;
  logic [LSB_ID_WIDTH-1:0] lsb_id_q, lsb_id_d;
  logic [31:0]             lsb_val_q, lsb_val_d;
  logic                    if_en_q, if_en_d;
  logic [31:0]             if_inst_q, if_inst_d;
  logic [31:0]             cap;
  logic                    stall_new, stall_cur;

`ifdef MEM_IO_STALL_EN
  assign stall_new = (lsb2mem_addr[17:16] == 2'b11) && io_buffer_full;
  assign stall_cur = (a_q[17:16] == 2'b11) && io_buffer_full;
`else
  // Feature disabled: the buffer-full flag never holds a store back.
  assign stall_new = 1'b0 & io_buffer_full;
  assign stall_cur = 1'b0;
`endif

  function automatic logic [2:0] nbytes(input logic [1:0] t);
    return t[1] ? 3'd4 : (t[0] ? 3'd2 : 3'd1);
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    sext_d    = sext_q;
    buf_d     = buf_q;
    id_d      = id_q;
    busy_d    = busy_q;
    wr_d      = wr_q;
    a_d       = a_q;
    dout_d    = dout_q;
    lsb_en_d  = lsb_en_q;
    lsb_id_d  = lsb_id_q;
    lsb_val_d = lsb_val_q;
    if_en_d   = if_en_q;
    if_inst_d = if_inst_q;

    // Byte cnt-1 arrives on mem_din one cycle after its address was driven.
    cap = buf_q;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q == 3'(i + 1)) cap[8*i +: 8] = mem_din;
    end

    if (rdy_in) begin
      lsb_en_d = 1'b0;
      if_en_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lsb2mem_en && (lsb2mem_store_load || !flush)) begin
            n_d    = nbytes(lsb2mem_type[1:0]);
            sext_d = !lsb2mem_type[2] && !lsb2mem_type[1];
            id_d   = lsb2mem_load_id;
            a_d    = lsb2mem_addr;
            cnt_d  = 3'd0;
            busy_d = 1'b1;
            if (lsb2mem_store_load) begin
              state_d = S_STORE;
              buf_d   = lsb2mem_val;
              dout_d  = lsb2mem_val[7:0];
              wr_d    = !stall_new;
            end else begin
              state_d = S_LOAD;
              buf_d   = 32'd0;
            end
          end else if (if2mem_en && !flush) begin
            state_d = S_FETCH;
            n_d     = 3'd4;
            sext_d  = 1'b0;
            a_d     = if2mem_addr;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            busy_d  = 1'b1;
          end
        end
        S_LOAD, S_FETCH: begin
          if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            if (cnt_q + 3'd1 < n_q) a_d = a_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q + 3'd1;
            buf_d = cap;
            if (cnt_q == n_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              if (state_q == S_LOAD) begin
                lsb_en_d = 1'b1;
                lsb_id_d = id_q;
                if (n_q == 3'd1)
                  lsb_val_d = {{24{sext_q & cap[7]}}, cap[7:0]};
                else if (n_q == 3'd2)
                  lsb_val_d = {{16{sext_q & cap[15]}}, cap[15:0]};
                else
                  lsb_val_d = cap;
              end else begin
                if_en_d   = 1'b1;
                if_inst_d = cap;
              end
            end
          end
        end
        default: begin
          // STORE: wr_q low with cnt_q < n_q means the current byte is stalled.
          if (wr_q) begin
            if (cnt_q + 3'd1 < n_q) begin
              cnt_d  = cnt_q + 3'd1;
              a_d    = a_q + ADDR_WIDTH'(1);
              dout_d = byte_of(buf_q, 2'(cnt_q + 3'd1));
              wr_d   = !stall_cur;
            end else begin
              wr_d  = 1'b0;
              cnt_d = n_q;
            end
          end else if (cnt_q == n_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else if (!stall_cur) begin
            wr_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      n_q       <= 3'd0;
      sext_q    <= 1'b0;
      buf_q     <= 32'd0;
      id_q      <= '0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      a_q       <= '0;
      dout_q    <= 8'd0;
      lsb_en_q  <= 1'b0;
      lsb_id_q  <= '0;
      lsb_val_q <= 32'd0;
      if_en_q   <= 1'b0;
      if_inst_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      sext_q    <= sext_d;
      buf_q     <= buf_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      a_q       <= a_d;
      dout_q    <= dout_d;
      lsb_en_q  <= lsb_en_d;
      lsb_id_q  <= lsb_id_d;
      lsb_val_q <= lsb_val_d;
      if_en_q   <= if_en_d;
      if_inst_q <= if_inst_d;
    end
  end

  assign mem_busy         = busy_q;
  assign mem_wr           = wr_q;
  assign mem_a            = a_q;
  assign mem_dout         = dout_q;
  assign mem2lsb_load_en  = lsb_en_q;
  assign mem2lsb_load_id  = lsb_id_q;
  assign mem2lsb_load_val = lsb_val_q;
  assign mem2if_en        = if_en_q;
  assign mem2if_inst      = if_inst_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a 1-cycle-latency byte RAM model.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        lsb2mem_en, lsb2mem_store_load;
  logic [31:0] lsb2mem_addr;
  logic [2:0]  lsb2mem_type;
  logic [31:0] lsb2mem_val;
  logic [2:0]  lsb2mem_load_id;
  logic        mem_busy, mem2lsb_load_en;
  logic [2:0]  mem2lsb_load_id;
  logic [31:0] mem2lsb_load_val;
  logic        if2mem_en;
  logic [31:0] if2mem_addr;
  logic        mem2if_en;
  logic [31:0] mem2if_inst;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram [0:1023];
  int          checks = 0;
  int          errors = 0;

  mem_controller #(.LSB_ID_WIDTH(3), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .lsb2mem_en(lsb2mem_en), .lsb2mem_store_load(lsb2mem_store_load),
    .lsb2mem_addr(lsb2mem_addr), .lsb2mem_type(lsb2mem_type),
    .lsb2mem_val(lsb2mem_val), .lsb2mem_load_id(lsb2mem_load_id),
    .mem_busy(mem_busy), .mem2lsb_load_en(mem2lsb_load_en),
    .mem2lsb_load_id(mem2lsb_load_id), .mem2lsb_load_val(mem2lsb_load_val),
    .if2mem_en(if2mem_en), .if2mem_addr(if2mem_addr),
    .mem2if_en(mem2if_en), .mem2if_inst(mem2if_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [2:0] ty, input logic [2:0] id,
                          output int lat, output int busy_cyc);
    lsb2mem_en = 1'b1; lsb2mem_store_load = 1'b0;
    lsb2mem_addr = addr; lsb2mem_type = ty; lsb2mem_load_id = id;
    tick();
    lsb2mem_en = 1'b0;
    lat = -1;
    busy_cyc = mem_busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_busy) busy_cyc++;
      if (mem2lsb_load_en) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic start_store(input logic [31:0] addr, input logic [2:0] ty, input logic [31:0] val);
    lsb2mem_en = 1'b1; lsb2mem_store_load = 1'b1;
    lsb2mem_addr = addr; lsb2mem_type = ty; lsb2mem_val = val;
    tick();
    lsb2mem_en = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int i = 0; i < 20; i++) begin
      if (!mem_busy) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int lat, busy_cyc, n, lsb_at, if_at, pulses;
    logic [31:0] lsb_v, if_v;

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h84;
    ram[10'h110] = 8'h80;
    ram[10'h120] = 8'h34; ram[10'h121] = 8'hF2;
    ram[10'h140] = 8'h13; ram[10'h141] = 8'h05; ram[10'h142] = 8'h00; ram[10'h143] = 8'h00;

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    lsb2mem_en = 1'b0; lsb2mem_store_load = 1'b0; lsb2mem_addr = '0;
    lsb2mem_type = '0; lsb2mem_val = '0; lsb2mem_load_id = '0;
    if2mem_en = 1'b0; if2mem_addr = '0; io_buffer_full = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, mem_busy}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_a", mem_a, 32'd0);
    chk("rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_lsb_en", {31'd0, mem2lsb_load_en}, 32'd0);
    chk("rst_lsb_val", mem2lsb_load_val, 32'd0);
    chk("rst_lsb_id", {29'd0, mem2lsb_load_id}, 32'd0);
    chk("rst_if_en", {31'd0, mem2if_en}, 32'd0);
    chk("rst_if_inst", mem2if_inst, 32'd0);
    rst_in = 1'b0;
    tick();

    // LW: pulse n+1 = 5 edges after the accept edge, busy for 5 cycles
    run_load(32'h100, 3'b010, 3'd5, lat, busy_cyc);
    chk("lw_lat", lat, 32'd5);
    chk("lw_busy", busy_cyc, 32'd5);
    chk("lw_val", mem2lsb_load_val, 32'h84332211);
    chk("lw_id", {29'd0, mem2lsb_load_id}, 32'd5);
    chk("lw_a_hold", mem_a, 32'h103);
    tick();
    chk("lw_pulse_one", {31'd0, mem2lsb_load_en}, 32'd0);

    run_load(32'h110, 3'b000, 3'd1, lat, busy_cyc);
    chk("lb_lat", lat, 32'd2);
    chk("lb_val", mem2lsb_load_val, 32'hFFFFFF80);
    // freeze while the pulse is high
    rdy_in = 1'b0;
    tick(); tick();
    chk("rdy_hold_pulse", {31'd0, mem2lsb_load_en}, 32'd1);
    chk("rdy_hold_val", mem2lsb_load_val, 32'hFFFFFF80);
    rdy_in = 1'b1;
    tick();
    chk("rdy_pulse_drop", {31'd0, mem2lsb_load_en}, 32'd0);

    run_load(32'h110, 3'b100, 3'd2, lat, busy_cyc);
    chk("lbu_val", mem2lsb_load_val, 32'h00000080);
    tick();
    run_load(32'h120, 3'b001, 3'd3, lat, busy_cyc);
    chk("lh_lat", lat, 32'd3);
    chk("lh_val", mem2lsb_load_val, 32'hFFFFF234);
    tick();
    run_load(32'h120, 3'b101, 3'd4, lat, busy_cyc);
    chk("lhu_val", mem2lsb_load_val, 32'h0000F234);
    tick();

    // SH 0xABCD1234 at 0x200
    start_store(32'h200, 3'b001, 32'hABCD1234);
    chk("sh_w0_wr", {31'd0, mem_wr}, 32'd1);
    chk("sh_w0_a", mem_a, 32'h200);
    chk("sh_w0_d", {24'd0, mem_dout}, 32'h34);
    tick();
    chk("sh_w1_wr", {31'd0, mem_wr}, 32'd1);
    chk("sh_w1_a", mem_a, 32'h201);
    chk("sh_w1_d", {24'd0, mem_dout}, 32'h12);
    tick();
    chk("sh_tail_wr", {31'd0, mem_wr}, 32'd0);
    chk("sh_tail_busy", {31'd0, mem_busy}, 32'd1);
    tick();
    chk("sh_idle", {31'd0, mem_busy}, 32'd0);
    chk("sh_ram", {ram[10'h202], ram[10'h201], ram[10'h200]}, 32'h001234);

    // LSB and fetch together: LSB first, fetch accepted right after
    lsb2mem_en = 1'b1; lsb2mem_store_load = 1'b0; lsb2mem_addr = 32'h100;
    lsb2mem_type = 3'b010; lsb2mem_load_id = 3'd2;
    if2mem_en = 1'b1; if2mem_addr = 32'h140;
    tick();
    lsb2mem_en = 1'b0;
    lsb_at = -1; if_at = -1; lsb_v = '0; if_v = '0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (mem2lsb_load_en) begin lsb_at = i; lsb_v = mem2lsb_load_val; end
      if (mem2if_en) begin
        if_at = i; if_v = mem2if_inst; if2mem_en = 1'b0;
        break;
      end
    end
    if2mem_en = 1'b0;
    chk("prio_lsb_at", lsb_at, 32'd5);
    chk("prio_lsb_val", lsb_v, 32'h84332211);
    chk("prio_if_at", if_at, 32'd11);
    chk("prio_if_inst", if_v, 32'h00000513);
    tick();

    // flush in the 2nd cycle of a fetch
    if2mem_en = 1'b1; if2mem_addr = 32'h140;
    tick();
    tick();
    flush = 1'b1; if2mem_en = 1'b0;
    tick();
    flush = 1'b0;
    chk("fflush_idle", {31'd0, mem_busy}, 32'd0);
    chk("fflush_wr", {31'd0, mem_wr}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem2if_en) pulses++;
      tick();
    end
    chk("fflush_no_pulse", pulses, 32'd0);

    // same flush during SW is ignored
    start_store(32'h300, 3'b010, 32'hDEADBEEF);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle(n);
    chk("sflush_done", {31'd0, (n >= 0)}, 32'd1);
    chk("sflush_ram", {ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]}, 32'hDEADBEEF);
    tick();

    // SB to I/O region with io_buffer_full high for 3 cycles
    io_buffer_full = 1'b1;
    start_store(32'h30000, 3'b000, 32'h0000005A);
`ifdef MEM_IO_STALL_EN
    chk("io_stall0", {31'd0, mem_wr}, 32'd0);
    tick();
    chk("io_stall1", {31'd0, mem_wr}, 32'd0);
    tick();
    chk("io_stall2", {31'd0, mem_wr}, 32'd0);
    io_buffer_full = 1'b0;
    tick();
    chk("io_write_wr", {31'd0, mem_wr}, 32'd1);
`else
    chk("io_write_wr", {31'd0, mem_wr}, 32'd1);
    io_buffer_full = 1'b0;
`endif
    chk("io_write_a", mem_a, 32'h30000);
    chk("io_write_d", {24'd0, mem_dout}, 32'h5A);
    wait_idle(n);
    chk("io_done", {31'd0, (n >= 0)}, 32'd1);
    chk("io_ram", {24'd0, ram[10'h000]}, 32'h5A);
    tick();

    // async reset in the middle of a load
    lsb2mem_en = 1'b1; lsb2mem_store_load = 1'b0; lsb2mem_addr = 32'h100;
    lsb2mem_type = 3'b010; lsb2mem_load_id = 3'd6;
    tick();
    lsb2mem_en = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, mem_busy}, 32'd0);
    chk("mrst_a", mem_a, 32'd0);
    tick();
    rst_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem2lsb_load_en) pulses++;
      tick();
    end
    chk("mrst_no_pulse", pulses, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
